// File: rtl/cell_comm_link_stats.sv
// -----------------------------------------------------------------------------
// cell_comm_link_stats
//
// Per-link Aurora receive statistics. Each link keeps four saturating counters:
//   0 = CRC faults, 1 = good frames, 2 = link drops, 3 = frame timeouts.
// Counters are read one at a time through a registered read port. An optional
// clear-on-read returns the pre-clear value.
//
// Optional feature: define CELL_COMM_LINK_STATS_WATCHDOG_EN to build the
// per-link idle watchdog that feeds the frame-timeout counter. Without it the
// timeout counter always reads 0.
//
// Parameters
//   NUM_LINKS   : number of monitored links (1..8)
//   CNT_WIDTH   : width of every statistics counter (8..32)
//   WDOG_CYCLES : idle clocks before a frame timeout (watchdog build only)
//
// Ports
//   auUserClk    : shared Aurora user clock
//   auUserResetN : asynchronous active-low reset (release synchronised inside)
//   rxTvalid     : per-link AXIS RX valid
//   rxTlast      : per-link AXIS RX last
//   rxCRCvalid   : per-link CRC result strobe
//   rxCRCpass    : per-link CRC pass flag
//   channelUp    : per-link Aurora channel-up status
//   rdLink       : link index for a read
//   rdCounter    : counter select for a read
//   rdStrobe     : read request
//   rdClear      : clear the selected counter after reading it
//   rdData       : read result, held until the next read
//   rdValid      : one-cycle pulse, rdData valid
//   linkUpMask   : channelUp delayed by one register
// -----------------------------------------------------------------------------
module cell_comm_link_stats #(
  parameter int NUM_LINKS   = 2,
  parameter int CNT_WIDTH   = 32,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                 auUserClk,
  input  logic                 auUserResetN,
  input  logic [NUM_LINKS-1:0] rxTvalid,
  input  logic [NUM_LINKS-1:0] rxTlast,
  input  logic [NUM_LINKS-1:0] rxCRCvalid,
  input  logic [NUM_LINKS-1:0] rxCRCpass,
  input  logic [NUM_LINKS-1:0] channelUp,
  input  logic [2:0]           rdLink,
  input  logic [1:0]           rdCounter,
  input  logic                 rdStrobe,
  input  logic                 rdClear,
  output logic [CNT_WIDTH-1:0] rdData,
  output logic                 rdValid,
  output logic [NUM_LINKS-1:0] linkUpMask
);

  localparam logic [3:0]           NUM_LINKS_W = 4'(NUM_LINKS);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = {CNT_WIDTH{1'b0}};

  // ---------------------------------------------------------------------------
  // Reset synchroniser: assertion is immediate, release is aligned to the clock.
  // Every other flop uses rst_n_int so the whole block leaves reset together.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_n_int;

  // Shift ones into the synchroniser after reset release.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Synchroniser flops, cleared directly by the external reset.
  always_ff @(posedge auUserClk or negedge auUserResetN) begin
    if (!auUserResetN) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n_int = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // Frame-timeout events
  // ---------------------------------------------------------------------------
  logic [NUM_LINKS-1:0] wdog_evt;

`ifdef CELL_COMM_LINK_STATS_WATCHDOG_EN
  localparam int                IDLE_W    = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(WDOG_CYCLES - 1);

  logic [IDLE_W-1:0] idle_q [NUM_LINKS];
  logic [IDLE_W-1:0] idle_d [NUM_LINKS];

  // Idle counter per link; a completed frame or a down link restarts it and
  // takes priority over the timeout.
  always_comb begin
    for (int l = 0; l < NUM_LINKS; l++) begin
      idle_d[l]   = idle_q[l];
      wdog_evt[l] = 1'b0;
      if (!channelUp[l] || (rxTvalid[l] && rxTlast[l])) begin
        idle_d[l] = {IDLE_W{1'b0}};
      end else if (idle_q[l] == IDLE_LAST) begin
        idle_d[l]   = {IDLE_W{1'b0}};
        wdog_evt[l] = 1'b1;
      end else begin
        idle_d[l] = idle_q[l] + IDLE_W'(1);
      end
    end
  end

  // Idle counter flops.
  always_ff @(posedge auUserClk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      for (int l = 0; l < NUM_LINKS; l++) begin
        idle_q[l] <= {IDLE_W{1'b0}};
      end
    end else begin
      for (int l = 0; l < NUM_LINKS; l++) begin
        idle_q[l] <= idle_d[l];
      end
    end
  end
`else
  // Frame framing inputs only matter to the watchdog.
  logic unused_wdog_inputs;
  assign unused_wdog_inputs = ^{rxTvalid, rxTlast, 32'(WDOG_CYCLES)};
  assign wdog_evt = {NUM_LINKS{1'b0}};
`endif

  // ---------------------------------------------------------------------------
  // Statistics counters
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] cnt_q [NUM_LINKS][4];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_LINKS][4];
  logic [3:0]           cnt_evt [NUM_LINKS];
  logic [NUM_LINKS-1:0] link_up_mask_q;
  logic                 rd_in_range;
  logic                 rd_clr_hit;

  assign rd_in_range = ({1'b0, rdLink} < NUM_LINKS_W);
  assign rd_clr_hit  = rdStrobe && rdClear && rd_in_range;

  // Per-counter increment events; drops compare against the registered mask
  // so a link that is already up when reset releases never counts as a drop.
  always_comb begin
    for (int l = 0; l < NUM_LINKS; l++) begin
      cnt_evt[l][0] = rxCRCvalid[l] && !rxCRCpass[l];
      cnt_evt[l][1] = rxCRCvalid[l] &&  rxCRCpass[l];
      cnt_evt[l][2] = link_up_mask_q[l] && !channelUp[l];
      cnt_evt[l][3] = wdog_evt[l];
    end
  end

  // Counter next state: clear-on-read wins, but a coincident event survives
  // the clear as a count of 1; otherwise increment with saturation.
  always_comb begin
    for (int l = 0; l < NUM_LINKS; l++) begin
      for (int c = 0; c < 4; c++) begin
        if (rd_clr_hit && (rdLink == 3'(l)) && (rdCounter == 2'(c))) begin
          cnt_d[l][c] = CNT_WIDTH'(cnt_evt[l][c]);
        end else if (cnt_evt[l][c] && (cnt_q[l][c] != CNT_MAX)) begin
          cnt_d[l][c] = cnt_q[l][c] + CNT_WIDTH'(1);
        end else begin
          cnt_d[l][c] = cnt_q[l][c];
        end
      end
    end
  end

  // Counter and link-mask flops.
  always_ff @(posedge auUserClk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      for (int l = 0; l < NUM_LINKS; l++) begin
        for (int c = 0; c < 4; c++) begin
          cnt_q[l][c] <= CNT_ZERO;
        end
      end
      link_up_mask_q <= {NUM_LINKS{1'b0}};
    end else begin
      for (int l = 0; l < NUM_LINKS; l++) begin
        for (int c = 0; c < 4; c++) begin
          cnt_q[l][c] <= cnt_d[l][c];
        end
      end
      link_up_mask_q <= channelUp;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port: value captured is the pre-update counter value.
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] rd_sel;
  logic [CNT_WIDTH-1:0] rd_data_q;
  logic [CNT_WIDTH-1:0] rd_data_d;
  logic                 rd_valid_q;
  logic                 rd_valid_d;

  // Select the addressed counter; an out-of-range link matches nothing.
  always_comb begin
    rd_sel = CNT_ZERO;
    for (int l = 0; l < NUM_LINKS; l++) begin
      if (rdLink == 3'(l)) begin
        rd_sel = cnt_q[l][rdCounter];
      end else begin
        rd_sel = rd_sel;
      end
    end
  end

  // Capture on strobe, otherwise hold the last result.
  always_comb begin
    rd_valid_d = rdStrobe;
    if (rdStrobe) begin
      rd_data_d = rd_in_range ? rd_sel : CNT_ZERO;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Read result flops.
  always_ff @(posedge auUserClk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      rd_data_q  <= CNT_ZERO;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rdData     = rd_data_q;
  assign rdValid    = rd_valid_q;
  assign linkUpMask = link_up_mask_q;

endmodule
